// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

  // Datapath width for the PC, the memory address and the instruction.
  localparam int unsigned DATA_W = 32;

  // Bubble instruction: sll $0,$0,0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch FSM encoding. Kept as plain 2-bit constants so existing
  // decoders and debug taps keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Update applied to the IF/ID register on a clock edge.
  typedef enum logic [1:0] {
    IFID_KEEP     = 2'd0,  // hold current contents
    IFID_LOAD_MEM = 2'd1,  // take the word returned by memory
    IFID_LOAD_BUF = 2'd2,  // take the word parked in the hold buffer
    IFID_BUBBLE   = 2'd3   // insert a NOP, valid=0
  } ifid_op_t;

endpackage

// File: rtl/ifid_skid_buf.sv
// IF/ID pipeline register plus a one-entry hold buffer. The buffer parks
// a fetched word while decode is stalled so the memory request can retire.
module ifid_skid_buf import if_pkg::*; #(
  parameter int unsigned     W      = 32,
  parameter logic [W-1:0]    BUBBLE = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  ifid_op_t     op_i,
  input  logic         capture_i,
  input  logic         inval_i,
  input  logic [W-1:0] mem_instr_i,
  input  logic [W-1:0] mem_pc4_i,
  output logic [W-1:0] ifid_instr_o,
  output logic [W-1:0] ifid_pc4_o,
  output logic         ifid_valid_o
);

  logic [W-1:0] buf_instr_q, buf_instr_d;
  logic [W-1:0] buf_pc4_q,   buf_pc4_d;
  logic         buf_valid_q, buf_valid_d;

  logic [W-1:0] ifid_instr_q, ifid_instr_d;
  logic [W-1:0] ifid_pc4_q,   ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;

  // Hold buffer next state: capture wins over invalidate.
  always_comb begin
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    buf_valid_d = buf_valid_q;
    if (capture_i) begin
      buf_instr_d = mem_instr_i;
      buf_pc4_d   = mem_pc4_i;
      buf_valid_d = 1'b1;
    end else if (inval_i) begin
      buf_valid_d = 1'b0;
    end
  end

  // IF/ID next state selected by the fetch controller.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    unique case (op_i)
      IFID_LOAD_MEM: begin
        ifid_instr_d = mem_instr_i;
        ifid_pc4_d   = mem_pc4_i;
        ifid_valid_d = 1'b1;
      end
      IFID_LOAD_BUF: begin
        ifid_instr_d = buf_instr_q;
        ifid_pc4_d   = buf_pc4_q;
        ifid_valid_d = buf_valid_q;
      end
      IFID_BUBBLE: begin
        ifid_instr_d = BUBBLE;
        ifid_pc4_d   = '0;
        ifid_valid_d = 1'b0;
      end
      default: begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
      end
    endcase
  end

  // Register both stages with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_instr_q  <= BUBBLE;
      buf_pc4_q    <= '0;
      buf_valid_q  <= 1'b0;
      ifid_instr_q <= BUBBLE;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
      buf_valid_q  <= buf_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues memory requests for the current PC,
// drives the PC write enable, and feeds the IF/ID register. A hazard stall
// parks the returned word in a hold buffer; a flush drains any request
// still outstanding so its data never reaches decode.
module if_fetch_unit #(
  parameter int unsigned        DATA_W    = if_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pcIn,
  input  logic              hzdWrite,
  input  logic              flush,
  output logic              imemReq,
  output logic [DATA_W-1:0] imemAddr,
  input  logic              imemReady,
  input  logic [DATA_W-1:0] imemData,
  output logic              pcWriteEn,
  output logic [DATA_W-1:0] pcPlus4,
  output logic [DATA_W-1:0] ifidInstr,
  output logic [DATA_W-1:0] ifidPcPlus4,
  output logic              ifidValid
);
  import if_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_hold_q, addr_hold_d;

  ifid_op_t ifid_op;
  logic     buf_capture;
  logic     buf_inval;
  logic     pc_we;

  assign pcPlus4 = pcIn + DATA_W'(4);

  // Request is live in FETCH and DRAIN; DRAIN replays the latched address
  // because the PC has already moved on to the flush target.
  assign imemReq  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imemAddr = (state_q == ST_FETCH) ? pcIn : addr_hold_q;
  assign pcWriteEn = pc_we;

  // Next-state, PC write enable and IF/ID / hold-buffer control.
  always_comb begin
    state_d     = state_q;
    addr_hold_d = addr_hold_q;
    pc_we       = 1'b0;
    ifid_op     = IFID_KEEP;
    buf_capture = 1'b0;
    buf_inval   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        addr_hold_d = pcIn;
        if (flush) begin
          pc_we     = 1'b1;
          ifid_op   = IFID_BUBBLE;
          buf_inval = 1'b1;
          state_d   = imemReady ? ST_FETCH : ST_DRAIN;
        end else if (imemReady) begin
          if (hzdWrite) begin
            pc_we   = 1'b1;
            ifid_op = IFID_LOAD_MEM;
          end else begin
            buf_capture = 1'b1;
            state_d     = ST_HOLD;
          end
        end else if (hzdWrite) begin
          ifid_op = IFID_BUBBLE;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          pc_we     = 1'b1;
          ifid_op   = IFID_BUBBLE;
          buf_inval = 1'b1;
        end else if (hzdWrite) begin
          ifid_op = IFID_BUBBLE;
        end
        if (imemReady) begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_we     = 1'b1;
          ifid_op   = IFID_BUBBLE;
          buf_inval = 1'b1;
          state_d   = ST_FETCH;
        end else if (hzdWrite) begin
          pc_we     = 1'b1;
          ifid_op   = IFID_LOAD_BUF;
          buf_inval = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and latched request address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  ifid_skid_buf #(
    .W      (DATA_W),
    .BUBBLE (NOP_INSTR)
  ) u_ifid (
    .clk_i        (clk),
    .rst_ni       (reset),
    .op_i         (ifid_op),
    .capture_i    (buf_capture),
    .inval_i      (buf_inval),
    .mem_instr_i  (imemData),
    .mem_pc4_i    (pcPlus4),
    .ifid_instr_o (ifidInstr),
    .ifid_pc4_o   (ifidPcPlus4),
    .ifid_valid_o (ifidValid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit with a scoreboard: each applied
// vector queues its expected outputs, and each instruction that should
// reach decode is queued separately; monitors pop and compare.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] pcIn;
  logic        hzdWrite;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        pcWriteEn;
  logic [31:0] pcPlus4;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;

  if_fetch_unit #(
    .DATA_W    (32),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pcIn        (pcIn),
    .hzdWrite    (hzdWrite),
    .flush       (flush),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemReady   (imemReady),
    .imemData    (imemData),
    .pcWriteEn   (pcWriteEn),
    .pcPlus4     (pcPlus4),
    .ifidInstr   (ifidInstr),
    .ifidPcPlus4 (ifidPcPlus4),
    .ifidValid   (ifidValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        req;
    logic [31:0] addr;
    logic        pcwe;
    logic [31:0] pp4;
    logic [31:0] instr;
    logic [31:0] ipc4;
    logic        vld;
    logic        chk_ipc4;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } dlv_t;

  exp_t expq[$];
  dlv_t dlvq[$];

  int errors = 0;
  int checks = 0;
  int vidx   = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s v%0d: got %h want %h", name, idx, got, want);
    end
  endtask

  // One cycle of stimulus plus its hand-computed expectations.
  task automatic apply(input logic rst, input logic [31:0] pc,
                       input logic hz, input logic fl, input logic rdy,
                       input logic [31:0] dat,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_pcwe, input logic [31:0] e_pp4,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc4,
                       input logic e_vld,
                       input logic dlv, input logic [31:0] dpc);
    exp_t e;
    dlv_t d;
    @(posedge clk);
    #1;
    reset     = rst;
    pcIn      = pc;
    hzdWrite  = hz;
    flush     = fl;
    imemReady = rdy;
    imemData  = dat;
    e.idx      = vidx;
    e.req      = e_req;
    e.addr     = e_addr;
    e.pcwe     = e_pcwe;
    e.pp4      = e_pp4;
    e.instr    = e_instr;
    e.ipc4     = e_ipc4;
    e.vld      = e_vld;
    e.chk_ipc4 = e_vld | ~rst;
    expq.push_back(e);
    if (dlv) begin
      d.instr = dat;
      d.pc4   = dpc;
      dlvq.push_back(d);
    end
    vidx++;
  endtask

  // Per-cycle output monitor.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("imemReq",   e.idx, {31'b0, imemReq},   {31'b0, e.req});
      check("imemAddr",  e.idx, imemAddr,           e.addr);
      check("pcWriteEn", e.idx, {31'b0, pcWriteEn}, {31'b0, e.pcwe});
      check("pcPlus4",   e.idx, pcPlus4,            e.pp4);
      check("ifidInstr", e.idx, ifidInstr,          e.instr);
      check("ifidValid", e.idx, {31'b0, ifidValid}, {31'b0, e.vld});
      if (e.chk_ipc4)
        check("ifidPcPlus4", e.idx, ifidPcPlus4, e.ipc4);
    end
  end

  // Delivery monitor: every new valid IF/ID word must be the next expected
  // instruction; anything else is a stale or lost fetch.
  logic        seen_valid = 1'b0;
  logic [31:0] last_instr = '0;
  logic [31:0] last_pc4   = '0;
  always @(negedge clk) begin
    dlv_t d;
    if (ifidValid === 1'b1) begin
      if (!(seen_valid && ifidInstr == last_instr && ifidPcPlus4 == last_pc4)) begin
        if (dlvq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL delivery: unexpected instr %h pc4 %h", ifidInstr, ifidPcPlus4);
        end else begin
          d = dlvq.pop_front();
          check("dlv_instr", -1, ifidInstr,   d.instr);
          check("dlv_pc4",   -1, ifidPcPlus4, d.pc4);
        end
      end
      seen_valid = 1'b1;
      last_instr = ifidInstr;
      last_pc4   = ifidPcPlus4;
    end else begin
      seen_valid = 1'b0;
    end
  end

  initial begin
    reset     = 1'b0;
    pcIn      = 32'h0040_0000;
    hzdWrite  = 1'b1;
    flush     = 1'b0;
    imemReady = 1'b0;
    imemData  = '0;

    //     rst pc            hz fl rdy data            req addr          we pcPlus4       ifidInstr     ifidPc4       vld dlv dpc
    // Reset, then zero-wait streaming.
    apply(0, 32'h0040_0000, 1, 0, 1, 32'h1111_1111,   0, 32'h0000_0000, 0, 32'h0040_0004, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0040_0000, 1, 0, 1, 32'h1111_1111,   0, 32'h0000_0000, 0, 32'h0040_0004, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0040_0000, 1, 0, 1, 32'h1111_1111,   1, 32'h0040_0000, 1, 32'h0040_0004, NOP,          32'h0,        0,  1, 32'h0040_0004);
    apply(1, 32'h0040_0004, 1, 0, 1, 32'h2222_2222,   1, 32'h0040_0004, 1, 32'h0040_0008, 32'h1111_1111, 32'h0040_0004, 1, 1, 32'h0040_0008);
    apply(1, 32'h0040_0008, 1, 0, 1, 32'h3333_3333,   1, 32'h0040_0008, 1, 32'h0040_000C, 32'h2222_2222, 32'h0040_0008, 1, 1, 32'h0040_000C);
    // Two wait states, data on the third request cycle.
    apply(1, 32'h0040_000C, 1, 0, 0, 32'h0000_0000,   1, 32'h0040_000C, 0, 32'h0040_0010, 32'h3333_3333, 32'h0040_000C, 1, 0, 32'h0);
    apply(1, 32'h0040_000C, 1, 0, 0, 32'h0000_0000,   1, 32'h0040_000C, 0, 32'h0040_0010, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0040_000C, 1, 0, 1, 32'h4444_4444,   1, 32'h0040_000C, 1, 32'h0040_0010, NOP,          32'h0,        0,  1, 32'h0040_0010);
    // Hazard stall when data returns: park in HOLD, then release.
    apply(1, 32'h0040_0010, 0, 0, 1, 32'h5555_5555,   1, 32'h0040_0010, 0, 32'h0040_0014, 32'h4444_4444, 32'h0040_0010, 1, 1, 32'h0040_0014);
    apply(1, 32'h0040_0010, 0, 0, 1, 32'hDEAD_BEEF,   0, 32'h0040_0010, 0, 32'h0040_0014, 32'h4444_4444, 32'h0040_0010, 1, 0, 32'h0);
    apply(1, 32'h0040_0010, 1, 0, 0, 32'h0000_0000,   0, 32'h0040_0010, 1, 32'h0040_0014, 32'h4444_4444, 32'h0040_0010, 1, 0, 32'h0);
    apply(1, 32'h0040_0014, 1, 0, 1, 32'h6666_6666,   1, 32'h0040_0014, 1, 32'h0040_0018, 32'h5555_5555, 32'h0040_0014, 1, 1, 32'h0040_0018);
    // Flush while a request to 0x100 is pending; DRAIN keeps 0x100.
    apply(1, 32'h0000_0100, 1, 0, 0, 32'h0000_0000,   1, 32'h0000_0100, 0, 32'h0000_0104, 32'h6666_6666, 32'h0040_0018, 1, 0, 32'h0);
    apply(1, 32'h0000_0100, 1, 1, 0, 32'h0000_0000,   1, 32'h0000_0100, 1, 32'h0000_0104, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0000_0200, 1, 0, 0, 32'h0000_0000,   1, 32'h0000_0100, 0, 32'h0000_0204, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0000_0200, 1, 0, 1, 32'hBADB_AD01,   1, 32'h0000_0100, 0, 32'h0000_0204, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0000_0200, 1, 0, 1, 32'h7777_7777,   1, 32'h0000_0200, 1, 32'h0000_0204, NOP,          32'h0,        0,  1, 32'h0000_0204);
    // Flush together with imemReady: data dropped, stay in FETCH.
    apply(1, 32'h0000_0204, 1, 1, 1, 32'hBADB_AD02,   1, 32'h0000_0204, 1, 32'h0000_0208, 32'h7777_7777, 32'h0000_0204, 1, 0, 32'h0);
    apply(1, 32'h0000_0300, 1, 0, 1, 32'h8888_8888,   1, 32'h0000_0300, 1, 32'h0000_0304, NOP,          32'h0,        0,  1, 32'h0000_0304);
    // Flush while in HOLD: buffered word must never appear.
    apply(1, 32'h0000_0304, 0, 0, 1, 32'hBADB_AD03,   1, 32'h0000_0304, 0, 32'h0000_0308, 32'h8888_8888, 32'h0000_0304, 1, 0, 32'h0);
    apply(1, 32'h0000_0304, 0, 1, 0, 32'h0000_0000,   0, 32'h0000_0304, 1, 32'h0000_0308, 32'h8888_8888, 32'h0000_0304, 1, 0, 32'h0);
    apply(1, 32'h0000_0400, 1, 0, 0, 32'h0000_0000,   1, 32'h0000_0400, 0, 32'h0000_0404, NOP,          32'h0,        0,  0, 32'h0);
    // Flush in FETCH without data, then repeated flushes in DRAIN.
    apply(1, 32'h0000_0400, 1, 1, 0, 32'h0000_0000,   1, 32'h0000_0400, 1, 32'h0000_0404, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0000_0500, 1, 1, 0, 32'h0000_0000,   1, 32'h0000_0400, 1, 32'h0000_0504, NOP,          32'h0,        0,  0, 32'h0);
    apply(1, 32'h0000_0600, 1, 1, 1, 32'hBADB_AD04,   1, 32'h0000_0400, 1, 32'h0000_0604, NOP,          32'h0,        0,  0, 32'h0);
    // PC+4 wraps at the top of the address space.
    apply(1, 32'hFFFF_FFFC, 1, 0, 1, 32'h9999_9999,   1, 32'hFFFF_FFFC, 1, 32'h0000_0000, NOP,          32'h0,        0,  1, 32'h0000_0000);
    apply(1, 32'h0000_0008, 0, 0, 0, 32'h0000_0000,   1, 32'h0000_0008, 0, 32'h0000_000C, 32'h9999_9999, 32'h0000_0000, 1, 0, 32'h0);
    // Reset asserted with a request outstanding.
    apply(0, 32'h0000_0008, 0, 0, 0, 32'h0000_0000,   0, 32'h0000_0000, 0, 32'h0000_000C, NOP,          32'h0,        0,  0, 32'h0);
    apply(0, 32'h0000_0008, 1, 0, 1, 32'h0000_0000,   0, 32'h0000_0000, 0, 32'h0000_000C, NOP,          32'h0,        0,  0, 32'h0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (dlvq.size() != 0 || expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d deliveries and %0d cycle records left, want 0",
               dlvq.size(), expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
